uart_rx_frame_ctrl: RTL

//  Sequences the byte stream from uart_rx into framed packets: SYNC, LEN, payload, CSUM.

---
 rtl/uart_rx_frame_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_rx byte stream (SYNC, LEN, payload, CSUM) into validated store-and-forward packets.
// Build option: define UART_RX_FRAME_CSUM_EN to require and check the trailing checksum byte.
module uart_rx_frame_ctrl #(
  parameter int unsigned DLEN    = 8,
  parameter int unsigned SYNC    = 'hA5,
  parameter int unsigned MAXLEN  = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_rvalid,
  input  logic [DLEN-1:0] i_rdata,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [DLEN-1:0] o_tdata,
  output logic            o_tlast,
  output logic            o_frame_ok,
  output logic            o_frame_err,
  output logic [2:0]      o_err_code,
  output logic            o_busy
);

  localparam int unsigned IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [DLEN-1:0] SYNC_B = DLEN'(SYNC);

  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic [IW-1:0]   last_idx;
  logic [TW-1:0]   idle_cnt;
  logic [DLEN-1:0] mem [MAXLEN];
`ifdef UART_RX_FRAME_CSUM_EN
  logic [DLEN-1:0] csum;
`endif

  logic          in_frame;
  logic          timeout_hit;
  logic [IW-1:0] rd_next;

  assign in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign timeout_hit = in_frame && !i_rvalid && (idle_cnt == TW'(TIMEOUT - 1));
  assign rd_next     = rd_idx + 1'b1;

  // NOTE: the payload buffer has no reset; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && i_rvalid) mem[wr_idx] <= i_rdata;
  end

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= HUNT;
      wr_idx      <= '0;
      rd_idx      <= '0;
      last_idx    <= '0;
      idle_cnt    <= '0;
`ifdef UART_RX_FRAME_CSUM_EN
      csum        <= '0;
`endif
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      if (in_frame) idle_cnt <= i_rvalid ? '0 : idle_cnt + 1'b1;

      if (timeout_hit) begin
        o_frame_err <= 1'b1;
        o_err_code  <= ERR_TIMEOUT;
        state       <= HUNT;
        o_busy      <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (i_rvalid && i_rdata == SYNC_B) begin
              state    <= LEN;
              idle_cnt <= '0;
              o_busy   <= 1'b1;
            end
          end
          LEN: begin
            if (i_rvalid) begin
              if (i_rdata == '0 || 32'(i_rdata) > MAXLEN) begin
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_LEN;
                state       <= HUNT;
                o_busy      <= 1'b0;
              end else begin
                last_idx <= IW'(i_rdata - 1'b1);
`ifdef UART_RX_FRAME_CSUM_EN
                csum     <= i_rdata;
`endif
                wr_idx   <= '0;
                state    <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (i_rvalid) begin
`ifdef UART_RX_FRAME_CSUM_EN
              csum <= csum + i_rdata;
              if (wr_idx == last_idx) state <= CSUM;
              else wr_idx <= wr_idx + 1'b1;
`else
              if (wr_idx == last_idx) begin
                // A 1-byte frame is still being written this cycle, so bypass the buffer.
                o_frame_ok <= 1'b1;
                o_tvalid   <= 1'b1;
                o_tdata    <= (wr_idx == '0) ? i_rdata : mem[0];
                o_tlast    <= (last_idx == '0);
                rd_idx     <= '0;
                state      <= DRAIN;
              end else begin
                wr_idx <= wr_idx + 1'b1;
              end
`endif
            end
          end
          CSUM: begin
`ifdef UART_RX_FRAME_CSUM_EN
            if (i_rvalid) begin
              if (i_rdata == csum) begin
                o_frame_ok <= 1'b1;
                o_tvalid   <= 1'b1;
                o_tdata    <= mem[0];
                o_tlast    <= (last_idx == '0);
                rd_idx     <= '0;
                state      <= DRAIN;
              end else begin
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_CSUM;
                state       <= HUNT;
                o_busy      <= 1'b0;
              end
            end
`else
            state  <= HUNT;
            o_busy <= 1'b0;
`endif
          end
          DRAIN: begin
            // uart_rx cannot be stalled, so a byte arriving now is lost and reported.
            if (i_rvalid) begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_OVERRUN;
            end
            if (o_tvalid && i_tready) begin
              if (o_tlast) begin
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
                state    <= HUNT;
                o_busy   <= 1'b0;
              end else begin
                rd_idx  <= rd_next;
                o_tdata <= mem[rd_next];
                o_tlast <= (rd_next == last_idx);
              end
            end
          end
          default: begin
            state  <= HUNT;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
